// File: rtl/flit_injector.sv
// flit_injector: packs PE collective requests into child-annotated flits,
// queues them and pulses them onto four gap-paced router inject ports.
// Ports: clk/rst (sync, active-high); req_* request handshake + fields;
//   inject_{xpos,ypos,xneg,yneg} one-cycle flit pulses (0 = idle);
//   pending = FIFO occupancy; sent_count = flits launched (mod 2^16).
// Optional: INJECT_DIR_AUTO_EN selects the port by dimension order
//   instead of req_dir.
module flit_injector #(
  parameter int cur_x = 0,
  parameter int cur_y = 0,
  parameter int cur_z = 0,
  parameter int lg_numprocs = 2,
  parameter int PayloadWidth = 32,
  parameter int FifoDepth = 8,
  parameter int InjectGap = 4,
  localparam int FlitChildWidth = PayloadWidth + 50 + lg_numprocs,
  localparam int PtrW = $clog2(FifoDepth)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [PayloadWidth-1:0]   req_payload,
  input  logic [3:0]                req_op,
  input  logic [1:0]                req_alg,
  input  logic [7:0]                req_tag,
  input  logic [7:0]                req_ctx,
  input  logic [8:0]                req_rank,
  input  logic [8:0]                req_dst,
  input  logic [1:0]                req_dir,
  input  logic [lg_numprocs-1:0]    req_children,
  output logic [FlitChildWidth-1:0] inject_xpos,
  output logic [FlitChildWidth-1:0] inject_ypos,
  output logic [FlitChildWidth-1:0] inject_xneg,
  output logic [FlitChildWidth-1:0] inject_yneg,
  output logic [PtrW:0]             pending,
  output logic [15:0]               sent_count
);

  localparam int GapW = (InjectGap > 1) ? $clog2(InjectGap) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(InjectGap - 1);
  localparam logic [GapW-1:0] GapOne = GapW'(1);
  localparam logic [PtrW:0] PtrOne = (PtrW+1)'(1);
  localparam logic [2:0] SrcX = 3'(cur_x);
  localparam logic [2:0] SrcY = 3'(cur_y);
  localparam logic [2:0] SrcZ = 3'(cur_z);

  logic [FlitChildWidth-1:0] req_flit;
  logic [1:0]                req_port;
  logic [FlitChildWidth-1:0] fifo_flit [FifoDepth];
  logic [1:0]                fifo_port [FifoDepth];
  logic [PtrW:0]             wr_ptr;
  logic [PtrW:0]             rd_ptr;
  logic                      full;
  logic                      empty;
  logic                      enq;
  logic                      launch;
  logic [1:0]                head_port;
  logic [FlitChildWidth-1:0] head_flit;
  logic [GapW-1:0]           gap [4];
  logic [FlitChildWidth-1:0] inj [4];

  assign req_flit = {req_children, 1'b1, req_dst,
                     SrcZ, SrcY, SrcX,
                     req_rank, req_ctx, req_tag,
                     req_alg, req_op, req_payload};

`ifdef INJECT_DIR_AUTO_EN
  logic [2:0] dst_x;
  logic [2:0] dst_y;
  logic       unused_dir;

  assign dst_x = req_dst[2:0];
  assign dst_y = req_dst[5:3];
  assign unused_dir = ^req_dir;

  // X first, then Y; a packet already at its X/Y goes out xpos.
  always_comb begin
    req_port = 2'd0;
    unique case (1'b1)
      (dst_x != SrcX):
        req_port = (dst_x > SrcX) ? 2'd0 : 2'd2;
      (dst_x == SrcX) && (dst_y != SrcY):
        req_port = (dst_y > SrcY) ? 2'd1 : 2'd3;
      default:
        req_port = 2'd0;
    endcase
  end
`else
  assign req_port = req_dir;
`endif

  // Extra pointer bit separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign req_ready = !full;
  assign enq = req_valid && !full && !rst;
  assign pending = wr_ptr - rd_ptr;

  assign head_port = fifo_port[rd_ptr[PtrW-1:0]];
  assign head_flit = fifo_flit[rd_ptr[PtrW-1:0]];
  assign launch = !empty && (gap[head_port] == '0) && !rst;

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_flit[wr_ptr[PtrW-1:0]] <= req_flit;
      fifo_port[wr_ptr[PtrW-1:0]] <= req_port;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sent_count <= '0;
      for (int i = 0; i < 4; i++) begin
        gap[i] <= '0;
        inj[i] <= '0;
      end
    end else begin
      if (enq) wr_ptr <= wr_ptr + PtrOne;
      if (launch) begin
        rd_ptr <= rd_ptr + PtrOne;
        sent_count <= sent_count + 16'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (launch && (head_port == 2'(i))) begin
          gap[i] <= GapLoad;
          inj[i] <= head_flit;
        end else begin
          inj[i] <= '0;
          if (gap[i] != '0) gap[i] <= gap[i] - GapOne;
        end
      end
    end
  end

  assign inject_xpos = inj[0];
  assign inject_ypos = inj[1];
  assign inject_xneg = inj[2];
  assign inject_yneg = inj[3];

endmodule
